ps2_arrow_decoder: RTL and testbench

Decodes the byte stream from `PS2_Controller` into clean arrow-key movement commands and an Enter strobe for the maze character mover (`conectBox`). It replaces direct equality decoding of the raw scan byte. It tracks the `E0` extended prefix and `F0` break prefix, keeps a held-state per arrow, and issues single-step move requests through a valid/ready handshake. It sits directly between `PS2_Controller` and `conectBox`.

---
 rtl/maze_pkg.sv | 56 +++++
 rtl/step_repeat_timer.sv | 64 ++++++
 rtl/ps2_arrow_decoder.sv | 143 ++++++++++++++
 tb/tb_ps2_arrow_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze types: direction codes, PS/2 scan-code constants and prefix FSM states.
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef logic [1:0] prefix_state_t;

    localparam prefix_state_t ST_IDLE    = 2'd0;
    localparam prefix_state_t ST_EXT     = 2'd1;
    localparam prefix_state_t ST_BRK     = 2'd2;
    localparam prefix_state_t ST_EXT_BRK = 2'd3;

    typedef struct packed {
        logic hit;
        dir_e dir;
    } arrow_code_t;

    // Maps the byte following an E0 prefix onto an arrow direction.
    function automatic arrow_code_t decode_arrow(input logic [7:0] code);
        arrow_code_t r;
        r.hit = 1'b1;
        r.dir = UP;
        case (code)
            SC_UP:    r.dir = UP;
            SC_DOWN:  r.dir = DOWN;
            SC_LEFT:  r.dir = LEFT;
            SC_RIGHT: r.dir = RIGHT;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // Highest-priority held direction: up > down > left > right.
    function automatic dir_e pick_dir(input logic [3:0] held);
        dir_e d;
        if (held[0])      d = UP;
        else if (held[1]) d = DOWN;
        else if (held[2]) d = LEFT;
        else              d = RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/step_repeat_timer.sv
// Auto-repeat timer: tracks the repeat direction and strobes expire_c when a
// held arrow is due for another step.
module step_repeat_timer
    import maze_pkg::*;
#(
    parameter int unsigned INITIAL_DELAY_CYCLES = 25_000_000,
    parameter int unsigned REPEAT_CYCLES        = 12_500_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] held_d_i,
    input  logic       make_i,
    input  dir_e       make_dir_i,
    input  logic       break_i,
    output logic       expire_c,
    output dir_e       rep_dir_o
);

    localparam int unsigned MAX_CYC = (INITIAL_DELAY_CYCLES > REPEAT_CYCLES)
                                      ? INITIAL_DELAY_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INITIAL_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    dir_e             next_dir_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            dir_q <= UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // A make always wins over expiry; a break only reloads if the direction moves.
    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        expire_c   = 1'b0;
        next_dir_c = pick_dir(held_d_i);
        if (held_d_i == 4'b0000) begin
            cnt_d = '0;
        end else if (make_i) begin
            dir_d = make_dir_i;
            cnt_d = INIT_LOAD;
        end else if (break_i && (next_dir_c != dir_q)) begin
            dir_d = next_dir_c;
            cnt_d = INIT_LOAD;
        end else if (cnt_q == '0) begin
            expire_c = 1'b1;
            cnt_d    = REP_LOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign rep_dir_o = dir_q;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 arrow/Enter decoder with one-deep step buffer.
// Define ARROW_REPEAT_EN to enable held-key auto-repeat via step_repeat_timer.
module ps2_arrow_decoder
    import maze_pkg::*;
#(
    parameter int unsigned INITIAL_DELAY_CYCLES = 25_000_000,
    parameter int unsigned REPEAT_CYCLES        = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       step_ready,
    output logic       step_valid,
    output logic [1:0] step_dir,
    output logic [3:0] held,
    output logic       enter_pulse,
    output logic       step_dropped
);

    prefix_state_t state_q, state_d;
    logic [3:0]    held_q, held_d;
    logic          step_valid_q, step_valid_d;
    dir_e          step_dir_q, step_dir_d;
    logic          enter_pulse_q, enter_pulse_d;
    logic          step_dropped_q, step_dropped_d;

    arrow_code_t   arrow_c;
    logic          make_c;
    logic          brk_c;
    logic          gen_c;
    dir_e          gen_dir_c;
    logic          expire_c;
    dir_e          rep_dir_c;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            held_q         <= 4'b0000;
            step_valid_q   <= 1'b0;
            step_dir_q     <= UP;
            enter_pulse_q  <= 1'b0;
            step_dropped_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            held_q         <= held_d;
            step_valid_q   <= step_valid_d;
            step_dir_q     <= step_dir_d;
            enter_pulse_q  <= enter_pulse_d;
            step_dropped_q <= step_dropped_d;
        end
    end

    // Prefix FSM and held-state tracking; a stray E0 after a break re-enters EXT.
    always_comb begin
        state_d       = state_q;
        held_d        = held_q;
        enter_pulse_d = 1'b0;
        make_c        = 1'b0;
        brk_c         = 1'b0;
        arrow_c       = decode_arrow(received_data);
        if (received_data_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (received_data == SC_EXT)        state_d = ST_EXT;
                    else if (received_data == SC_BRK)   state_d = ST_BRK;
                    else if (received_data == SC_ENTER) enter_pulse_d = 1'b1;
                end
                ST_EXT: begin
                    if (received_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (arrow_c.hit && !held_q[arrow_c.dir]) begin
                            make_c                = 1'b1;
                            held_d[arrow_c.dir]   = 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    state_d = (received_data == SC_EXT) ? ST_EXT : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = (received_data == SC_EXT) ? ST_EXT : ST_IDLE;
                    if (arrow_c.hit && held_q[arrow_c.dir]) begin
                        brk_c               = 1'b1;
                        held_d[arrow_c.dir] = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // One-deep step buffer; a new step while blocked is dropped, not queued.
    always_comb begin
        gen_c          = make_c | expire_c;
        gen_dir_c      = make_c ? arrow_c.dir : rep_dir_c;
        step_valid_d   = step_valid_q;
        step_dir_d     = step_dir_q;
        step_dropped_d = step_dropped_q;
        if (step_valid_q && step_ready) begin
            step_valid_d = 1'b0;
        end
        if (gen_c) begin
            if (!step_valid_q || step_ready) begin
                step_valid_d = 1'b1;
                step_dir_d   = gen_dir_c;
            end else begin
                step_dropped_d = 1'b1;
            end
        end
    end

`ifdef ARROW_REPEAT_EN
    step_repeat_timer #(
        .INITIAL_DELAY_CYCLES (INITIAL_DELAY_CYCLES),
        .REPEAT_CYCLES        (REPEAT_CYCLES)
    ) u_repeat (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .held_d_i   (held_d),
        .make_i     (make_c),
        .make_dir_i (arrow_c.dir),
        .break_i    (brk_c),
        .expire_c   (expire_c),
        .rep_dir_o  (rep_dir_c)
    );
`else
    logic unused_cfg_c;

    assign expire_c     = 1'b0;
    assign rep_dir_c    = UP;
    assign unused_cfg_c = ^{brk_c, 32'(INITIAL_DELAY_CYCLES), 32'(REPEAT_CYCLES)};
`endif

    assign step_valid   = step_valid_q;
    assign step_dir     = step_dir_q;
    assign held         = held_q;
    assign enter_pulse  = enter_pulse_q;
    assign step_dropped = step_dropped_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench for ps2_arrow_decoder (INITIAL_DELAY_CYCLES=10, REPEAT_CYCLES=4).
module tb_ps2_arrow_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       step_ready = 1'b1;
    logic       step_valid;
    logic [1:0] step_dir;
    logic [3:0] held;
    logic       enter_pulse;
    logic       step_dropped;

    int n_cmp = 0;
    int n_err = 0;
    int step_total = 0;

    ps2_arrow_decoder #(
        .INITIAL_DELAY_CYCLES (10),
        .REPEAT_CYCLES        (4)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .step_ready       (step_ready),
        .step_valid       (step_valid),
        .step_dir         (step_dir),
        .held             (held),
        .enter_pulse      (enter_pulse),
        .step_dropped     (step_dropped)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Count accepted steps
    always @(posedge CLOCK_50) begin
        if (step_valid && step_ready) step_total <= step_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns on the falling edge after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK_50);
    endtask

    initial begin
        int          base;
        logic [31:0] obs_mask;
        logic [31:0] exp_mask;

        idle(2);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_held", 32'(held), 32'h0);
        chk("rst_valid", 32'(step_valid), 32'h0);
        chk("rst_dir", 32'(step_dir), 32'h0);
        chk("rst_enter", 32'(enter_pulse), 32'h0);
        chk("rst_dropped", 32'(step_dropped), 32'h0);

        // Make and break of up
        base = step_total;
        send(8'hE0); send(8'h75);
        chk("up_held", 32'(held), 32'h1);
        chk("up_valid", 32'(step_valid), 32'h1);
        chk("up_dir", 32'(step_dir), 32'h0);
        @(negedge CLOCK_50);
        chk("up_valid_clr", 32'(step_valid), 32'h0);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_brk_held", 32'(held), 32'h0);
        idle(15);
        chk("up_steps", 32'(step_total - base), 32'd1);

        // Hold right, record step timing offsets after the make
        exp_mask = 32'h0;
        exp_mask[1] = 1'b1;
`ifdef ARROW_REPEAT_EN
        exp_mask[11] = 1'b1;
        exp_mask[15] = 1'b1;
        exp_mask[19] = 1'b1;
        exp_mask[23] = 1'b1;
        exp_mask[27] = 1'b1;
`endif
        obs_mask = 32'h0;
        send(8'hE0); send(8'h74);
        chk("rt_dir", 32'(step_dir), 32'h3);
        for (int k = 1; k <= 30; k++) begin
            obs_mask[k] = step_valid;
            @(negedge CLOCK_50);
        end
        chk("rt_repeat_mask", obs_mask, exp_mask);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("rt_brk_held", 32'(held), 32'h0);
        idle(5);

        // Typematic resend of right
        base = step_total;
        for (int r = 0; r < 3; r++) begin
            send(8'hE0); send(8'h74);
        end
        idle(2);
        chk("typ_steps", 32'(step_total - base), 32'd1);
        chk("typ_held", 32'(held), 32'h8);
        send(8'hE0); send(8'hF0); send(8'h74);
        idle(3);

        // Blocked consumer: second make is dropped
        step_ready = 1'b0;
        send(8'hE0); send(8'h75);
        chk("blk_valid", 32'(step_valid), 32'h1);
        chk("blk_dir0", 32'(step_dir), 32'h0);
        send(8'hE0); send(8'h6B);
        chk("blk_dir1", 32'(step_dir), 32'h0);
        chk("blk_dropped", 32'(step_dropped), 32'h1);
        chk("blk_held", 32'(held), 32'h5);
        step_ready = 1'b1;
        @(negedge CLOCK_50);
        chk("blk_valid_clr", 32'(step_valid), 32'h0);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("blk_rel_held", 32'(held), 32'h0);
        idle(3);

        // Non-extended break, unknown extended code, Enter, stray prefix
        send(8'hE0); send(8'h75);
        send(8'hF0); send(8'h75);
        chk("nx_brk_held", 32'(held), 32'h1);
        send(8'hE0); send(8'h12);
        chk("ext_unk_held", 32'(held), 32'h1);
        send(8'h5A);
        chk("enter_hi", 32'(enter_pulse), 32'h1);
        @(negedge CLOCK_50);
        chk("enter_lo", 32'(enter_pulse), 32'h0);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_rel2", 32'(held), 32'h0);
        send(8'hF0); send(8'hE0); send(8'h74);
        chk("stray_prefix", 32'(held), 32'h8);
        send(8'hE0); send(8'hF0); send(8'h74);
        idle(3);

        // Reset mid-sequence discards the E0 prefix
        send(8'hE0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        chk("mid_rst_dropped", 32'(step_dropped), 32'h0);
        send(8'h75);
        chk("mid_rst_valid", 32'(step_valid), 32'h0);
        chk("mid_rst_held", 32'(held), 32'h0);
        send(8'hE0); send(8'h72);
        chk("post_rst_held", 32'(held), 32'h2);
        chk("post_rst_dir", 32'(step_dir), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
